// File: rtl/mem_dump_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_sequencer_if
// Description : Bus bundle between the memory dump sequencer, the debug port
//               of the memory stage and the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_dump_sequencer_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5
);
    // Memory debug port
    logic [NB_ADDR-1:0] o_addr_mem_debug_unit;
    logic               o_ctrl_addr_debug_mem;
    logic               o_ctrl_wr_debug_mem;
    logic [NB_DATA-1:0] i_mem_data;
    logic               i_bit_sucio;
    // UART transmitter handshake
    logic [7:0]         o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;

    // Sequencer side
    modport master (
        output o_addr_mem_debug_unit,
        output o_ctrl_addr_debug_mem,
        output o_ctrl_wr_debug_mem,
        input  i_mem_data,
        input  i_bit_sucio,
        output o_tx_data,
        output o_tx_start,
        input  i_tx_done
    );

    // Memory stage / UART side
    modport slave (
        input  o_addr_mem_debug_unit,
        input  o_ctrl_addr_debug_mem,
        input  o_ctrl_wr_debug_mem,
        output i_mem_data,
        output i_bit_sucio,
        input  o_tx_data,
        input  o_tx_start,
        output i_tx_done
    );
endinterface
`default_nettype wire

// File: rtl/mem_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_sequencer
// Description : After a pipeline halt, takes ownership of the data memory,
//               sweeps every word address, and streams each word (optionally
//               only dirty words, prefixed with their address) to the UART
//               transmitter one byte at a time, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_sequencer #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int N_WORDS    = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_only_dirty,
    mem_dump_sequencer_if.master bus,
    output logic                 o_busy,
    output logic                 o_done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_NB_BYTES = NB_DATA / 8;
    // One spare byte on top of the data word holds the address prefix
    localparam int c_NB_BUF   = NB_DATA + 8;
    localparam int c_NB_WAIT  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int c_NB_CNT   = $clog2(c_NB_BYTES + 2);

    localparam logic [c_NB_WAIT-1:0] c_WAIT_LOAD = c_NB_WAIT'(RD_LATENCY - 1);
    localparam logic [NB_ADDR-1:0]   c_LAST_ADDR = NB_ADDR'(N_WORDS - 1);
    localparam logic [c_NB_CNT-1:0]  c_CNT_ONE   = c_NB_CNT'(1);
    localparam logic [c_NB_CNT-1:0]  c_CNT_WORD  = c_NB_CNT'(c_NB_BYTES);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_ADDR    = 3'd1;
    localparam logic [2:0] c_S_WAIT    = 3'd2;
    localparam logic [2:0] c_S_CAPTURE = 3'd3;
    localparam logic [2:0] c_S_SEND    = 3'd4;
    localparam logic [2:0] c_S_WAIT_TX = 3'd5;
    localparam logic [2:0] c_S_NEXT    = 3'd6;
    localparam logic [2:0] c_S_DONE    = 3'd7;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    logic [2:0]           state_q,      state_d;
    logic [NB_ADDR-1:0]   addr_q,       addr_d;       // sweep counter
    logic [NB_ADDR-1:0]   addr_out_q,   addr_out_d;   // address seen by memory
    logic [c_NB_WAIT-1:0] wait_q,       wait_d;
    logic [c_NB_CNT-1:0]  byte_cnt_q,   byte_cnt_d;
    logic [c_NB_BUF-1:0]  shift_q,      shift_d;
    logic                 only_dirty_q, only_dirty_d;

    logic [7:0]           w_addr_byte;
    logic [c_NB_BUF-1:0]  w_capture_buf;
    logic                 w_active;

    // ------------------------------------------------------------------------
    // Address prefix byte: zero-extended, or low byte for wide addresses
    // ------------------------------------------------------------------------
    generate
        if (NB_ADDR >= 8) begin : g_addr_trunc
            assign w_addr_byte = addr_q[7:0];
        end else begin : g_addr_zext
            assign w_addr_byte = {{(8 - NB_ADDR){1'b0}}, addr_q};
        end
    endgenerate

    // The top byte of the shift buffer is always the byte on the wire. In
    // dirty-only mode the address sits above the data so it goes out first.
    assign w_capture_buf = only_dirty_q ? {w_addr_byte, bus.i_mem_data}
                                        : {bus.i_mem_data, 8'h00};

    // Memory is owned (and forced to read) whenever a sweep is in progress
    assign w_active = (state_q != c_S_IDLE) && (state_q != c_S_DONE);

    assign bus.o_addr_mem_debug_unit = addr_out_q;
    assign bus.o_ctrl_addr_debug_mem = w_active;
    assign bus.o_ctrl_wr_debug_mem   = w_active;
    assign bus.o_tx_data             = shift_q[c_NB_BUF-1 -: 8];
    assign bus.o_tx_start            = (state_q == c_S_SEND);
    assign o_busy                    = w_active;
    assign o_done                    = (state_q == c_S_DONE);

    // Next-state logic for the sweep / capture / transmit sequence
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        addr_out_d   = addr_out_q;
        wait_d       = wait_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        only_dirty_d = only_dirty_q;

        case (state_q)
            c_S_IDLE: begin
                if (i_start) begin
                    only_dirty_d = i_only_dirty;
                    addr_d       = '0;
                    state_d      = c_S_ADDR;
                end
            end

            c_S_ADDR: begin
                // Address becomes visible to the memory from the next cycle
                addr_out_d = addr_q;
                wait_d     = c_WAIT_LOAD;
                state_d    = c_S_WAIT;
            end

            c_S_WAIT: begin
                if (wait_q == '0) begin
                    state_d = c_S_CAPTURE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            c_S_CAPTURE: begin
                if (only_dirty_q && !bus.i_bit_sucio) begin
                    // Clean word skipped; buffer left untouched so the
                    // transmit byte only ever changes on entry to SEND
                    state_d = c_S_NEXT;
                end else begin
                    shift_d    = w_capture_buf;
                    byte_cnt_d = c_CNT_WORD + c_NB_CNT'(only_dirty_q);
                    state_d    = c_S_SEND;
                end
            end

            c_S_SEND: begin
                state_d = c_S_WAIT_TX;
            end

            c_S_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    byte_cnt_d = byte_cnt_q - 1'b1;
                    if (byte_cnt_q != c_CNT_ONE) begin
                        shift_d = shift_q << 8;
                        state_d = c_S_SEND;
                    end else begin
                        state_d = c_S_NEXT;
                    end
                end
            end

            c_S_NEXT: begin
                if (addr_q == c_LAST_ADDR) begin
                    state_d = c_S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = c_S_ADDR;
                end
            end

            c_S_DONE: begin
                state_d = c_S_IDLE;
            end

            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any dump in progress
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= c_S_IDLE;
            addr_q       <= '0;
            addr_out_q   <= '0;
            wait_q       <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            only_dirty_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_out_q   <= addr_out_d;
            wait_q       <= wait_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            only_dirty_q <= only_dirty_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dump_sequencer
// Description : Self-checking bench for mem_dump_sequencer. Three instances
//               with read latencies 1, 2 and 3 share one preloaded memory
//               image; expected UART bytes are queued per instance and a
//               monitor per instance pops and compares each tx_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_sequencer;

    logic clk = 1'b0;
    logic [2:0] rst_v, start_v, od_v, spur_v, busy_v, done_v;
    // {addr[4:0], ctrl_addr, ctrl_wr, tx_data[7:0], tx_start, busy, done}
    logic [2:0][17:0] obs_v;

    logic [31:0] mem   [32];
    logic        dirty [32];

    logic [7:0] expq [3][$];
    int ntx [3];
    int ndone [3];
    int done_cyc [3];
    int cyc_cnt   = 0;
    int start_cyc = 0;
    int total     = 0;
    int bad       = 0;

    // Dirty-mode dump of words 3 and 17
    logic [7:0] t2_bytes [10] = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h03,
                                  8'h11, 8'h10, 8'h00, 8'h00, 8'h11};

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = g + 1;

        mem_dump_sequencer_if #(.NB_DATA(32), .NB_ADDR(5)) bus ();

        mem_dump_sequencer #(
            .NB_DATA   (32),
            .NB_ADDR   (5),
            .N_WORDS   (32),
            .RD_LATENCY(LAT)
        ) u_dut (
            .i_clock     (clk),
            .i_reset     (rst_v[g]),
            .i_start     (start_v[g]),
            .i_only_dirty(od_v[g]),
            .bus         (bus),
            .o_busy      (busy_v[g]),
            .o_done      (done_v[g])
        );

        assign obs_v[g] = {bus.o_addr_mem_debug_unit, bus.o_ctrl_addr_debug_mem,
                           bus.o_ctrl_wr_debug_mem, bus.o_tx_data,
                           bus.o_tx_start, busy_v[g], done_v[g]};

        // Memory read pipeline of LAT stages; garbage when not owned
        logic [31:0] dpipe [LAT];
        logic        spipe [LAT];
        always @(posedge clk) begin
            if (bus.o_ctrl_addr_debug_mem && bus.o_ctrl_wr_debug_mem) begin
                dpipe[0] <= mem[bus.o_addr_mem_debug_unit];
                spipe[0] <= dirty[bus.o_addr_mem_debug_unit];
            end else begin
                dpipe[0] <= 32'hDEADBEEF;
                spipe[0] <= 1'b1;
            end
            for (int k = 1; k < LAT; k++) begin
                dpipe[k] <= dpipe[k-1];
                spipe[k] <= spipe[k-1];
            end
        end
        assign bus.i_mem_data  = dpipe[LAT-1];
        assign bus.i_bit_sucio = spipe[LAT-1];

        // UART model: done pulse about ten cycles after each start
        int   txc;
        logic tdm;
        always @(posedge clk) begin
            if (rst_v[g]) begin
                txc <= 0;
                tdm <= 1'b0;
            end else begin
                tdm <= (txc == 1);
                if (bus.o_tx_start) txc <= 10;
                else if (txc != 0)  txc <= txc - 1;
            end
        end
        assign bus.i_tx_done = tdm | spur_v[g];

        // Monitor: pops expected bytes on every tx_start, checks done pulses
        logic [7:0] e;
        initial begin : mon
            forever begin
                @(negedge clk);
                if (bus.o_tx_start) begin
                    ntx[g]++;
                    total++;
                    if (expq[g].size() == 0) begin
                        bad++;
                        $display("FAIL tx_unexpected inst=%0d got=%02h required=none",
                                 g, bus.o_tx_data);
                    end else begin
                        e = expq[g].pop_front();
                        if (bus.o_tx_data !== e) begin
                            bad++;
                            $display("FAIL tx_byte inst=%0d n=%0d got=%02h required=%02h",
                                     g, ntx[g], bus.o_tx_data, e);
                        end
                    end
                end
                if (done_v[g]) begin
                    ndone[g]++;
                    done_cyc[g] = cyc_cnt;
                    total++;
                    if ({bus.o_ctrl_addr_debug_mem, bus.o_ctrl_wr_debug_mem, busy_v[g]} !== 3'b000) begin
                        bad++;
                        $display("FAIL done_ctrl inst=%0d got=%b required=000", g,
                                 {bus.o_ctrl_addr_debug_mem, bus.o_ctrl_wr_debug_mem, busy_v[g]});
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic push_word(input int i, input int a, input logic [31:0] d, input bit with_addr);
        logic [7:0] b;
        if (with_addr) begin
            b = 8'(a);
            expq[i].push_back(b);
        end
        for (int k = 3; k >= 0; k--) begin
            b = d[k*8 +: 8];
            expq[i].push_back(b);
        end
    endtask

    task automatic run_dump(input logic [2:0] mask, input logic od, input int exp_bytes,
                            input string tag);
        int base_d [3];
        int base_t [3];
        int cyc;
        bit all_done;
        for (int i = 0; i < 3; i++) begin
            base_d[i] = ndone[i];
            base_t[i] = ntx[i];
        end
        od_v      = {3{od}};
        start_cyc = cyc_cnt;
        start_v   = mask;
        tick(1);
        start_v   = 3'b000;
        tick(4);
        for (int i = 0; i < 3; i++)
            if (mask[i])
                check($sformatf("%s_active%0d", tag, i),
                      {obs_v[i][12], obs_v[i][11], obs_v[i][1]}, 3'b111);
        cyc      = 0;
        all_done = 1'b0;
        while (!all_done && cyc < 20000) begin
            all_done = 1'b1;
            for (int i = 0; i < 3; i++)
                if (mask[i] && ndone[i] == base_d[i]) all_done = 1'b0;
            if (!all_done) begin
                tick(1);
                cyc++;
            end
        end
        if (!all_done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_done required=done", tag);
        end
        tick(15);
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                check($sformatf("%s_done_count%0d", tag, i), ndone[i] - base_d[i], 1);
                check($sformatf("%s_byte_count%0d", tag, i), ntx[i] - base_t[i], exp_bytes);
                check($sformatf("%s_queue_left%0d", tag, i), expq[i].size(), 0);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_t;
        int k;
        int n;
        int d;

        for (int a = 0; a < 32; a++) begin
            mem[a]   = 32'h1000_0000 + a;
            dirty[a] = 1'b0;
        end
        rst_v   = 3'b111;
        start_v = 3'b000;
        od_v    = 3'b000;
        spur_v  = 3'b000;

        // Reset state
        tick(3);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_outputs%0d", i), obs_v[i], 0);
        rst_v = 3'b000;
        tick(2);

        // Full dump, all latencies
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 32; a++) push_word(i, a, mem[a], 1'b0);
        run_dump(3'b111, 1'b0, 128, "full");

        // Dirty-only dump of words 3 and 17
        dirty[3]  = 1'b1;
        dirty[17] = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 10; j++) expq[i].push_back(t2_bytes[j]);
        run_dump(3'b111, 1'b1, 10, "dirty");

        // Reset during the third byte of word 5 (latency 2 instance)
        for (int a = 0; a < 5; a++) push_word(1, a, mem[a], 1'b0);
        expq[1].push_back(8'h10);
        expq[1].push_back(8'h00);
        expq[1].push_back(8'h00);
        base_t     = ntx[1];
        od_v       = 3'b000;
        start_v[1] = 1'b1;
        tick(1);
        start_v[1] = 1'b0;
        k = 0;
        while ((ntx[1] - base_t) < 23 && k < 5000) begin
            tick(1);
            k++;
        end
        check("abort_reached_byte23", ntx[1] - base_t, 23);
        tick(2);
        rst_v[1] = 1'b1;
        tick(1);
        check("abort_outputs_zero", obs_v[1], 0);
        rst_v[1] = 1'b0;
        tick(60);
        check("abort_no_more_tx", ntx[1] - base_t, 23);
        check("abort_still_idle", obs_v[1], 0);
        check("abort_queue_left", expq[1].size(), 0);
        for (int a = 0; a < 32; a++) push_word(1, a, mem[a], 1'b0);
        run_dump(3'b010, 1'b0, 128, "restart");

        // All clean, dirty-only: no bytes, sweep timing per latency
        dirty[3]  = 1'b0;
        dirty[17] = 1'b0;
        run_dump(3'b111, 1'b1, 0, "clean");
        for (int i = 0; i < 3; i++) begin
            n = 32 * (i + 1 + 3) + 2;
            d = done_cyc[i] - start_cyc;
            total++;
            if (d < n - 1 || d > n + 1) begin
                bad++;
                $display("FAIL clean_timing inst=%0d got=%0d required=%0d+-1", i, d, n);
            end
        end

        // Start pulses while busy and a spurious tx_done during WAIT
        dirty[3]  = 1'b1;
        dirty[17] = 1'b1;
        for (int j = 0; j < 10; j++) expq[1].push_back(t2_bytes[j]);
        fork
            run_dump(3'b010, 1'b1, 10, "disturb");
            begin
                k = 0;
                while (obs_v[1][17:13] != 5'd2 && k < 3000) begin
                    tick(1);
                    k++;
                end
                spur_v[1] = 1'b1;
                tick(1);
                spur_v[1] = 1'b0;
                tick(2);
                start_v[1] = 1'b1;
                tick(1);
                start_v[1] = 1'b0;
                tick(150);
                start_v[1] = 1'b1;
                tick(1);
                start_v[1] = 1'b0;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
